// File: rtl/ctx_stack.sv
`default_nettype none
// ============================================================================
// Module   : ctx_stack
// Purpose  : Multi-context hardware call stack (LIFO) with combinational
//            top-of-stack read, occupancy and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module ctx_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 15,
    parameter int NCTX  = 1,
    parameter int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CTX_W-1:0] ctx,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] writedata,
    input  logic             err_clr,
    output logic [WIDTH-1:0] readdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic             w_valid;
    logic [WIDTH-1:0] w_top [NCTX];
    logic [CNT_W-1:0] w_cnt [NCTX];
    logic             w_ovf [NCTX];
    logic             w_unf [NCTX];

    // Out-of-range context selects nothing, so it neither modifies state nor drives outputs.
    assign w_valid = ({1'b0, ctx} < (CTX_W + 1)'(NCTX));

    genvar i;
    generate
        for (i = 0; i < NCTX; i++) begin : g_ctx
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;
            logic             r_unf;
            logic             w_sel;
            logic             w_full;
            logic             w_empty;
            logic             w_we;
            logic             w_inc;
            logic             w_dec;
            logic             w_ovf_set;
            logic             w_unf_set;
            logic [CNT_W-1:0] w_waddr;

            assign w_sel     = w_valid && (ctx == CTX_W'(i));
            assign w_full    = (r_cnt == C_DEPTH);
            assign w_empty   = (r_cnt == '0);
            // Push+pop on a non-empty stack overwrites the top; on an empty one it is a plain push.
            assign w_waddr   = (pop && !w_empty) ? (r_cnt - 1'b1) : r_cnt;
            assign w_we      = w_sel && push && (pop || !w_full);
            assign w_inc     = w_sel && push && (pop ? w_empty : !w_full);
            assign w_dec     = w_sel && pop && !push && !w_empty;
            assign w_ovf_set = w_sel && push && !pop && w_full;
            assign w_unf_set = w_sel && pop && !push && w_empty;

            always_ff @(posedge clk) begin
                if (!reset && w_we) begin
                    r_mem[w_waddr] <= writedata;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end else begin
                    if (w_inc) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_dec) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    r_ovf <= w_ovf_set || (r_ovf && !(w_sel && err_clr));
                    r_unf <= w_unf_set || (r_unf && !(w_sel && err_clr));
                end
            end

            assign w_top[i] = w_empty ? '0 : r_mem[r_cnt - 1'b1];
            assign w_cnt[i] = r_cnt;
            assign w_ovf[i] = r_ovf;
            assign w_unf[i] = r_unf;
        end
    endgenerate

    always_comb begin
        readdata  = '0;
        count     = '0;
        empty     = 1'b0;
        full      = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        for (int k = 0; k < NCTX; k++) begin
            if (w_valid && (ctx == CTX_W'(k))) begin
                readdata  = w_top[k];
                count     = w_cnt[k];
                empty     = (w_cnt[k] == '0);
                full      = (w_cnt[k] == C_DEPTH);
                overflow  = w_ovf[k];
                underflow = w_unf[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctx_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctx_stack
// Purpose  : Self-checking bench for ctx_stack against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctx_stack;

    localparam int WIDTH = 12;
    localparam int DEPTH = 15;
    localparam int NCTX  = 4;
    localparam int CTX_W = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [CTX_W-1:0] ctx = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] writedata = '0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] readdata;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per context, back of queue is top of stack.
    logic [WIDTH-1:0] m_stk [NCTX][$];
    bit               m_ovf [NCTX];
    bit               m_unf [NCTX];

    ctx_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCTX(NCTX)) dut (
        .clk(clk), .reset(reset), .ctx(ctx), .push(push), .pop(pop),
        .writedata(writedata), .err_clr(err_clr), .readdata(readdata),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_rd(input int c);
        return (m_stk[c].size() == 0) ? '0 : m_stk[c][m_stk[c].size() - 1];
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int c);
        return CNT_W'(m_stk[c].size());
    endfunction

    function automatic void model_op(input int c, input bit p, input bit q,
                                     input logic [WIDTH-1:0] d, input bit clr);
        int sz;
        sz = m_stk[c].size();
        if (clr) begin
            m_ovf[c] = 1'b0;
            m_unf[c] = 1'b0;
        end
        if (p && q) begin
            if (sz == 0) m_stk[c].push_back(d);
            else         m_stk[c][sz - 1] = d;
        end else if (p) begin
            if (sz == DEPTH) m_ovf[c] = 1'b1;
            else             m_stk[c].push_back(d);
        end else if (q) begin
            if (sz == 0) m_unf[c] = 1'b1;
            else         void'(m_stk[c].pop_back());
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCTX; c++) begin
            m_stk[c].delete();
            m_ovf[c] = 1'b0;
            m_unf[c] = 1'b0;
        end
    endfunction

    task automatic step(input int c, input bit p, input bit q,
                        input logic [WIDTH-1:0] d, input bit clr);
        @(negedge clk);
        ctx = CTX_W'(c); push = p; pop = q; writedata = d; err_clr = clr;
        @(posedge clk);
        model_op(c, p, q, d, clr);
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset(input bit with_push);
        @(negedge clk);
        reset = 1'b1; push = with_push; writedata = 12'h5A5;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0; push = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        for (int c = 0; c < NCTX; c++) begin
            ctx = CTX_W'(c);
            #1;
            checks++;
            if (readdata !== '0 || count !== '0 || empty !== 1'b1 || full !== 1'b0 ||
                overflow !== 1'b0 || underflow !== 1'b0) begin
                $display("FAIL reset ctx%0d: rd=%h cnt=%0d e=%b f=%b o=%b u=%b, want 0 0 1 0 0 0",
                         c, readdata, count, empty, full, overflow, underflow);
                errors++;
            end
        end
    endtask

    task automatic test_basic();
        step(0, 1, 0, 12'h123, 0);
        step(0, 1, 0, 12'h456, 0);
        step(0, 1, 0, 12'h789, 0);
        checks++;
        if (readdata !== 12'h789 || count !== 4'd3) begin
            $display("FAIL basic_push: rd=%h cnt=%0d, want 789 3", readdata, count);
            errors++;
        end
        step(0, 0, 1, '0, 0);
        checks++;
        if (readdata !== 12'h456) begin
            $display("FAIL basic_pop1: rd=%h, want 456", readdata);
            errors++;
        end
        step(0, 0, 1, '0, 0);
        checks++;
        if (readdata !== 12'h123) begin
            $display("FAIL basic_pop2: rd=%h, want 123", readdata);
            errors++;
        end
        step(0, 0, 1, '0, 0);
        checks++;
        if (empty !== 1'b1 || readdata !== '0 || underflow !== 1'b0) begin
            $display("FAIL basic_pop3: e=%b rd=%h u=%b, want 1 000 0", empty, readdata, underflow);
            errors++;
        end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] last;
        for (int k = 0; k < DEPTH; k++) begin
            last = 12'($urandom);
            step(1, 1, 0, last, 0);
        end
        step(1, 1, 0, 12'hABC, 0);
        checks++;
        if (full !== 1'b1 || count !== 4'd15 || overflow !== 1'b1 || readdata !== last) begin
            $display("FAIL full_ovf: f=%b cnt=%0d o=%b rd=%h, want 1 15 1 %h",
                     full, count, overflow, readdata, last);
            errors++;
        end
        step(1, 1, 1, 12'hDEF, 0);
        checks++;
        if (readdata !== 12'hDEF || count !== 4'd15 || underflow !== 1'b0) begin
            $display("FAIL full_replace: rd=%h cnt=%0d u=%b, want DEF 15 0", readdata, count, underflow);
            errors++;
        end
    endtask

    task automatic test_underflow();
        step(2, 0, 1, '0, 0);
        checks++;
        if (underflow !== 1'b1 || count !== '0) begin
            $display("FAIL unf_set: u=%b cnt=%0d, want 1 0", underflow, count);
            errors++;
        end
        step(2, 0, 0, '0, 1);
        checks++;
        if (underflow !== 1'b0) begin
            $display("FAIL unf_clr: u=%b, want 0", underflow);
            errors++;
        end
        step(2, 0, 1, '0, 1);
        checks++;
        if (underflow !== 1'b1) begin
            $display("FAIL unf_set_wins: u=%b, want 1", underflow);
            errors++;
        end
    endtask

    task automatic test_ctx_switch();
        do_reset(1'b0);
        step(0, 1, 0, 12'h111, 0);
        step(3, 1, 0, 12'h222, 0);
        step(1, 1, 0, 12'h333, 0);
        step(2, 0, 1, '0, 0);
        for (int k = 0; k < 6; k++) begin
            ctx = (k % 2 == 0) ? 2'd0 : 2'd3;
            #1;
            checks++;
            if (readdata !== ((k % 2 == 0) ? 12'h111 : 12'h222) || count !== 4'd1) begin
                $display("FAIL ctx_switch%0d: rd=%h cnt=%0d, want %h 1", k, readdata, count,
                         (k % 2 == 0) ? 12'h111 : 12'h222);
                errors++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pushpop_empty();
        do_reset(1'b0);
        step(1, 1, 1, 12'h0AA, 0);
        checks++;
        if (count !== 4'd1 || readdata !== 12'h0AA || overflow !== 1'b0 || underflow !== 1'b0) begin
            $display("FAIL pushpop_empty: cnt=%0d rd=%h o=%b u=%b, want 1 0AA 0 0",
                     count, readdata, overflow, underflow);
            errors++;
        end
    endtask

    task automatic test_reset_priority();
        for (int k = 0; k < DEPTH + 1; k++) step(0, 1, 0, 12'($urandom), 0);
        for (int k = 0; k < DEPTH - 5; k++) step(0, 0, 1, '0, 0);
        checks++;
        if (count !== 4'd5 || overflow !== 1'b1) begin
            $display("FAIL pre_reset: cnt=%0d o=%b, want 5 1", count, overflow);
            errors++;
        end
        do_reset(1'b1);
        checks++;
        if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0 || readdata !== '0) begin
            $display("FAIL reset_push: cnt=%0d e=%b o=%b rd=%h, want 0 1 0 000",
                     count, empty, overflow, readdata);
            errors++;
        end
    endtask

    task automatic test_random();
        int c;
        int o;
        bit p;
        bit q;
        bit clr;
        for (int n = 0; n < 400; n++) begin
            c   = $urandom_range(NCTX - 1);
            p   = ($urandom_range(99) < 55);
            q   = ($urandom_range(99) < 45);
            clr = ($urandom_range(99) < 8);
            step(c, p, q, 12'($urandom), clr);
            checks++;
            if (readdata !== exp_rd(c) || count !== exp_cnt(c) ||
                empty !== (m_stk[c].size() == 0) || full !== (m_stk[c].size() == DEPTH) ||
                overflow !== m_ovf[c] || underflow !== m_unf[c]) begin
                $display("FAIL random n=%0d ctx%0d: rd=%h cnt=%0d o=%b u=%b, want %h %0d %b %b",
                         n, c, readdata, count, overflow, underflow,
                         exp_rd(c), exp_cnt(c), m_ovf[c], m_unf[c]);
                errors++;
            end
            o = $urandom_range(NCTX - 1);
            ctx = CTX_W'(o);
            #1;
            checks++;
            if (readdata !== exp_rd(o) || count !== exp_cnt(o) ||
                overflow !== m_ovf[o] || underflow !== m_unf[o]) begin
                $display("FAIL random_other n=%0d ctx%0d: rd=%h cnt=%0d o=%b u=%b, want %h %0d %b %b",
                         n, o, readdata, count, overflow, underflow,
                         exp_rd(o), exp_cnt(o), m_ovf[o], m_unf[o]);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_ctx_switch();
        test_pushpop_empty();
        test_reset_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctx_stack.md
# ctx_stack

Parametrised multi-context LIFO for subroutine return addresses, the next-generation hardware call stack for the ez8 core. Holds NCTX independent stacks, one per hardware thread/interrupt context, selected by `ctx`. Adds occupancy count, full/empty for the selected context, and per-context sticky overflow/underflow error flags that the sequencer can read and clear. Top-of-stack read is combinational, so a `pop` and the return target are available in the same cycle.

## Interface
Parameters:
- WIDTH, 12, entry width in bits (return address size)
- DEPTH, 15, entries per context, ≥2
- NCTX, 1, number of independent contexts, ≥1
- CTX_W, max(1, clog2(NCTX)), width of the context select (derived)
- CNT_W, clog2(DEPTH+1), width of the occupancy count (derived)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ctx  in  CTX_W  selects the context for all operations and for all outputs; values ≥NCTX are ignored, behaving as no-op with all outputs 0
- push  in  1  write `writedata` as the new top of the selected context
- pop  in  1  discard the top of the selected context
- writedata  in  WIDTH  data to push
- err_clr  in  1  clear the selected context's sticky error flags
- readdata  out  WIDTH  top of the selected context; 0 when empty
- count  out  CNT_W  entries held by the selected context
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky flag for the selected context: push attempted while full
- underflow  out  1  sticky flag for the selected context: pop attempted while empty

## Operation
- Per context state: storage of DEPTH×WIDTH, a count register of CNT_W bits, and overflow/underflow flags. The storage is not reset.
- All outputs are combinational from the state of the selected `ctx`. There is no registered output stage.
- Action per cycle on the selected context, decided from (push, pop, count):
  - push only, not full: mem[count] ← writedata; count+1.
  - push only, full: no write, count unchanged, overflow ← 1.
  - pop only, not empty: count−1.
  - pop only, empty: count unchanged, underflow ← 1.
  - push+pop, not empty: replace top, mem[count−1] ← writedata; count unchanged; no flag, even if full.
  - push+pop, empty: behaves as push only (count becomes 1); no underflow.
  - neither: hold.
- Non-selected contexts are never modified.
- err_clr clears both flags of the selected context. If an error occurs in the same cycle, set wins and the flag stays 1.
- Count arithmetic is saturating by construction: it never wraps past DEPTH or below 0.

## Timing
- Reset: after the edge with reset=1, every context has count=0 and both flags 0. Outputs: readdata=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- Reset has priority over push, pop and err_clr in the same cycle. Reset asserted mid-sequence discards all contents.
- An operation sampled at edge N is visible on the outputs immediately after edge N (zero-cycle read latency).
- A change of `ctx` changes the outputs combinationally in the same cycle; there is no settling cycle.
- No handshake. Callers check `full`/`empty` themselves; misuse is recorded in the flags and is never silently corrupting.

## Test plan
- Reset, then push 0x123, 0x456, 0x789 on ctx 0 (WIDTH=12, DEPTH=15, NCTX=4) -> readdata 0x789, count 3; three pops return 0x456, then 0x123, then empty=1 with readdata=0.
- Push 15 values on ctx 1, then push 0xABC -> full=1, count 15, overflow=1, top unchanged. Push+pop with 0xDEF -> top 0xDEF, count 15.
- Pop on empty ctx 2 -> underflow=1, count 0. Assert err_clr alone -> underflow=0. Assert err_clr together with another empty pop -> underflow stays 1.
- Push 0x111 on ctx 0 and 0x222 on ctx 3, then switch ctx each cycle -> readdata alternates 0x111/0x222. Counts remain 1 and are unaffected by the other context's operations.
- Push+pop 0x0AA on empty ctx 1 -> count 1, readdata 0x0AA, no flags set.
- Fill ctx 0 to count 5 with overflow set, assert reset together with push -> count 0, empty=1, overflow=0, and no entry written.
